// File: rtl/iagu_win_gen.sv
// Input-address generator for convolution windows: walks oy, ox, ky, kx and emits one
// bank read (or a padding marker) per kernel tap, with a valid/ready handshake.
module iagu_win_gen #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 1,
  parameter int DIM_W  = 8,
  parameter int KER_W  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [BANK_W+ADDR_W-1:0]   i_base_addr,
  input  logic [DIM_W-1:0]           i_in_x_len,
  input  logic [DIM_W-1:0]           i_in_y_len,
  input  logic [DIM_W-1:0]           i_out_x_len,
  input  logic [DIM_W-1:0]           i_out_y_len,
  input  logic [KER_W-1:0]           i_kernel,
  input  logic [1:0]                 i_stride,
  input  logic [1:0]                 i_pad,
  input  logic [ADDR_W-1:0]          i_line_size,
  input  logic                       i_ready,
  output logic [(1<<BANK_W)-1:0]     o_rd_en,
  output logic [ADDR_W-1:0]          o_raddr,
  output logic                       o_pad_en,
  output logic                       o_win_last,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NUM_BANKS = 1 << BANK_W;
  localparam int CW        = DIM_W + KER_W + 3;
  localparam int PW        = ADDR_W + CW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 r_state, w_state_nxt;

  logic [BANK_W-1:0]      r_bank;
  logic [ADDR_W-1:0]      r_base, r_line;
  logic [DIM_W-1:0]       r_in_x, r_in_y, r_out_x, r_out_y;
  logic [KER_W-1:0]       r_k;
  logic [1:0]             r_s, r_p;

  logic [KER_W-1:0]       w_k_in;
  logic [1:0]             w_s_in;
  logic                   w_load;

  logic [BANK_W-1:0]      w_bank;
  logic [ADDR_W-1:0]      w_base, w_line;
  logic [DIM_W-1:0]       w_in_x, w_in_y;
  logic [KER_W-1:0]       w_k;
  logic [1:0]             w_s, w_p;

  logic [DIM_W-1:0]       r_oy, r_ox, w_oy_n, w_ox_n, w_adv_oy, w_adv_ox, w_sel_oy, w_sel_ox;
  logic [KER_W-1:0]       r_ky, r_kx, w_ky_n, w_kx_n, w_adv_ky, w_adv_kx, w_sel_ky, w_sel_kx;
  logic                   w_last, w_vld;

  logic signed [CW-1:0]   w_iy, w_ix;
  logic                   w_oob;
  logic [NUM_BANKS-1:0]   w_el_rd_en;
  logic [ADDR_W-1:0]      w_el_raddr;
  logic                   w_el_last;

  logic [NUM_BANKS-1:0]   r_rd_en, w_rd_en_n;
  logic [ADDR_W-1:0]      r_raddr, w_raddr_n;
  logic                   r_pad_en, w_pad_en_n;
  logic                   r_win_last, w_win_last_n;
  logic                   r_busy, w_busy_n;
  logic                   r_done, w_done_n;

  function automatic logic signed [CW-1:0] coord(input logic [DIM_W-1:0] o,
                                                 input logic [1:0]       s,
                                                 input logic [KER_W-1:0] k,
                                                 input logic [1:0]       p);
    coord = $signed({{(CW-DIM_W){1'b0}}, o}) * $signed({{(CW-2){1'b0}}, s})
          + $signed({{(CW-KER_W){1'b0}}, k}) - $signed({{(CW-2){1'b0}}, p});
  endfunction

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [CW-1:0]     iy,
                                                 input logic [CW-1:0]     ix,
                                                 input logic [ADDR_W-1:0] line);
    logic [PW-1:0] prod;
    prod = PW'(iy) * PW'(line) + PW'(ix) + PW'(base);
    return prod[ADDR_W-1:0];
  endfunction

  assign w_k_in = (i_kernel == '0) ? KER_W'(1) : i_kernel;
  assign w_s_in = (i_stride == '0) ? 2'd1 : i_stride;
  assign w_load = (r_state == S_IDLE) && i_start && !i_abort;

  // While idle the first element is built straight from the live inputs.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_bank = i_base_addr[BANK_W+ADDR_W-1:ADDR_W];
      w_base = i_base_addr[ADDR_W-1:0];
      w_line = i_line_size;
      w_in_x = i_in_x_len;
      w_in_y = i_in_y_len;
      w_k    = w_k_in;
      w_s    = w_s_in;
      w_p    = i_pad;
    end else begin
      w_bank = r_bank;
      w_base = r_base;
      w_line = r_line;
      w_in_x = r_in_x;
      w_in_y = r_in_y;
      w_k    = r_k;
      w_s    = r_s;
      w_p    = r_p;
    end
  end

  always_comb begin
    w_adv_oy = r_oy;
    w_adv_ox = r_ox;
    w_adv_ky = r_ky;
    w_adv_kx = r_kx;
    if (r_kx != r_k - KER_W'(1)) begin
      w_adv_kx = r_kx + KER_W'(1);
    end else begin
      w_adv_kx = '0;
      if (r_ky != r_k - KER_W'(1)) begin
        w_adv_ky = r_ky + KER_W'(1);
      end else begin
        w_adv_ky = '0;
        if (r_ox != r_out_x - DIM_W'(1)) begin
          w_adv_ox = r_ox + DIM_W'(1);
        end else begin
          w_adv_ox = '0;
          w_adv_oy = r_oy + DIM_W'(1);
        end
      end
    end
  end

  assign w_last = (r_kx == r_k - KER_W'(1)) && (r_ky == r_k - KER_W'(1)) &&
                  (r_ox == r_out_x - DIM_W'(1)) && (r_oy == r_out_y - DIM_W'(1));
  assign w_vld  = (|r_rd_en) | r_pad_en;

  assign w_sel_oy = (r_state == S_IDLE) ? '0 : w_adv_oy;
  assign w_sel_ox = (r_state == S_IDLE) ? '0 : w_adv_ox;
  assign w_sel_ky = (r_state == S_IDLE) ? '0 : w_adv_ky;
  assign w_sel_kx = (r_state == S_IDLE) ? '0 : w_adv_kx;

  assign w_iy  = coord(w_sel_oy, w_s, w_sel_ky, w_p);
  assign w_ix  = coord(w_sel_ox, w_s, w_sel_kx, w_p);
  assign w_oob = w_iy[CW-1] || w_ix[CW-1] ||
                 (w_iy >= $signed({{(CW-DIM_W){1'b0}}, w_in_y})) ||
                 (w_ix >= $signed({{(CW-DIM_W){1'b0}}, w_in_x}));

  assign w_el_rd_en = w_oob ? '0 : (NUM_BANKS'(1) << w_bank);
  assign w_el_raddr = w_oob ? '0 : lin_addr(w_base, w_iy, w_ix, w_line);
  assign w_el_last  = (w_sel_ky == w_k - KER_W'(1)) && (w_sel_kx == w_k - KER_W'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_oy_n       = r_oy;
    w_ox_n       = r_ox;
    w_ky_n       = r_ky;
    w_kx_n       = r_kx;
    w_rd_en_n    = r_rd_en;
    w_raddr_n    = r_raddr;
    w_pad_en_n   = r_pad_en;
    w_win_last_n = r_win_last;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    if (i_abort) begin
      w_state_nxt  = S_IDLE;
      w_rd_en_n    = '0;
      w_raddr_n    = '0;
      w_pad_en_n   = 1'b0;
      w_win_last_n = 1'b0;
      w_busy_n     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if ((i_out_x_len == '0) || (i_out_y_len == '0)) begin
              w_state_nxt = S_DONE;
              w_done_n    = 1'b1;
            end else begin
              w_state_nxt  = S_RUN;
              w_oy_n       = '0;
              w_ox_n       = '0;
              w_ky_n       = '0;
              w_kx_n       = '0;
              w_rd_en_n    = w_el_rd_en;
              w_raddr_n    = w_el_raddr;
              w_pad_en_n   = w_oob;
              w_win_last_n = w_el_last;
              w_busy_n     = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_vld && i_ready) begin
            if (w_last) begin
              w_state_nxt  = S_DONE;
              w_rd_en_n    = '0;
              w_raddr_n    = '0;
              w_pad_en_n   = 1'b0;
              w_win_last_n = 1'b0;
              w_busy_n     = 1'b0;
              w_done_n     = 1'b1;
            end else begin
              w_oy_n       = w_adv_oy;
              w_ox_n       = w_adv_ox;
              w_ky_n       = w_adv_ky;
              w_kx_n       = w_adv_kx;
              w_rd_en_n    = w_el_rd_en;
              w_raddr_n    = w_el_raddr;
              w_pad_en_n   = w_oob;
              w_win_last_n = w_el_last;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_oy       <= '0;
      r_ox       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_rd_en    <= '0;
      r_raddr    <= '0;
      r_pad_en   <= 1'b0;
      r_win_last <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_oy       <= w_oy_n;
      r_ox       <= w_ox_n;
      r_ky       <= w_ky_n;
      r_kx       <= w_kx_n;
      r_rd_en    <= w_rd_en_n;
      r_raddr    <= w_raddr_n;
      r_pad_en   <= w_pad_en_n;
      r_win_last <= w_win_last_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
    end
  end

  // Job configuration is frozen at launch.
  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_bank  <= i_base_addr[BANK_W+ADDR_W-1:ADDR_W];
      r_base  <= i_base_addr[ADDR_W-1:0];
      r_line  <= i_line_size;
      r_in_x  <= i_in_x_len;
      r_in_y  <= i_in_y_len;
      r_out_x <= i_out_x_len;
      r_out_y <= i_out_y_len;
      r_k     <= w_k_in;
      r_s     <= w_s_in;
      r_p     <= i_pad;
    end
  end

  assign o_rd_en    = r_rd_en;
  assign o_raddr    = r_raddr;
  assign o_pad_en   = r_pad_en;
  assign o_win_last = r_win_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
